// File: rtl/mem_pipe_param.sv
// Parametrised single-port memory with a valid/ready request channel,
// fixed-latency in-order responses, a clear-after-reset sequencer and
// out-of-range address error reporting.
module mem_pipe_param #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned CLEAR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMP_W = ADDR_W + 1;
    localparam int unsigned LAST  = DEPTH - 1;

    // Reject configurations the address decode and pipeline cannot support.
    if (DEPTH < 1 || longint'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
        $error("mem_pipe_param: DEPTH must be in 1..2**ADDR_W");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("mem_pipe_param: RD_LAT must be in 1..4");
    end

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    rsp_t              pipe [RD_LAT];

    logic              accept_c;
    logic              in_range_c;
    logic [IDX_W-1:0]  idx_c;
    rsp_t              stage_in_c;

    assign accept_c   = req_valid && req_ready;
    // Widened compare so DEPTH == 2**ADDR_W does not wrap to zero.
    assign in_range_c = {1'b0, req_addr} < CMP_W'(DEPTH);
    assign idx_c      = IDX_W'(req_addr);

    // Init sequencer: sweep the clear counter, then sit in READY until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            cnt       <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (CLEAR_ON_RST == 0 || cnt == IDX_W'(LAST)) begin
                        state     <= ST_READY;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    req_ready <= 1'b1;
                    init_done <= 1'b1;
                end
                default: begin
                    state     <= ST_INIT;
                    req_ready <= 1'b0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: zero-fill during init, otherwise accepted in-range writes.
    always_ff @(posedge clk) begin
        if (CLEAR_ON_RST != 0 && state == ST_INIT) begin
            mem[cnt] <= '0;
        end else if (accept_c && req_write && in_range_c) begin
            mem[idx_c] <= req_wdata;
        end
    end

    // Response entering the latency pipeline; data is zero unless a good read.
    always_comb begin
        stage_in_c = '0;
        if (accept_c) begin
            stage_in_c.valid = 1'b1;
            stage_in_c.err   = !in_range_c;
            if (!req_write && in_range_c) begin
                stage_in_c.data = mem[idx_c];
            end
        end
    end

    // Fixed-latency shift pipeline; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(RD_LAT); k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0] <= stage_in_c;
            for (int k = 1; k < int'(RD_LAT); k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign rsp_valid = pipe[RD_LAT-1].valid;
    assign rsp_err   = pipe[RD_LAT-1].err;
    assign rsp_data  = pipe[RD_LAT-1].data;

endmodule

// File: tb/tb_mem_pipe_param.sv
// Bench for mem_pipe_param: three configurations driven by one shared
// request stream and checked every cycle against a queue-based model.
module tb_mem_pipe_param;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid;
    logic       req_write;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;

    logic       rdy [NI];
    logic       vld [NI];
    logic       err [NI];
    logic       ini [NI];
    logic [7:0] dat [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Configuration 0: defaults (32 words, latency 1, cleared).
    mem_pipe_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_LAT(1), .CLEAR_ON_RST(1)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld[0]), .rsp_data(dat[0]), .rsp_err(err[0]), .init_done(ini[0]));

    // Configuration 1: 20 words, latency 3, cleared.
    mem_pipe_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .RD_LAT(3), .CLEAR_ON_RST(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld[1]), .rsp_data(dat[1]), .rsp_err(err[1]), .init_done(ini[1]));

    // Configuration 2: 32 words, latency 4, not cleared.
    mem_pipe_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_LAT(4), .CLEAR_ON_RST(0)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[2]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld[2]), .rsp_data(dat[2]), .rsp_err(err[2]), .init_done(ini[2]));

    function automatic int dep(int i);
        return (i == 1) ? 20 : 32;
    endfunction

    function automatic int lat(int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    function automatic bit clr(int i);
        return i != 2;
    endfunction

    // ---------------- behavioural model ----------------
    int         edges   [NI];
    bit         m_ready [NI];
    logic [7:0] m_mem   [NI][32];
    bit         m_known [NI][32];
    int         f_due   [NI][64];
    bit         f_err   [NI][64];
    logic [7:0] f_dat   [NI][64];
    bit         f_kn    [NI][64];
    int         f_head  [NI];
    int         f_tail  [NI];
    bit         e_valid [NI];
    bit         e_err   [NI];
    bit         e_kn    [NI];
    logic [7:0] e_dat   [NI];

    function automatic void model_reset(int i);
        edges[i]   = 0;
        m_ready[i] = 1'b0;
        f_head[i]  = 0;
        f_tail[i]  = 0;
        e_valid[i] = 1'b0;
        e_err[i]   = 1'b0;
        e_kn[i]    = 1'b1;
        e_dat[i]   = 8'h00;
        for (int a = 0; a < 32; a++) begin
            m_mem[i][a]   = 8'h00;
            m_known[i][a] = clr(i);
        end
    endfunction

    function automatic void model_step(int i);
        bit acc;
        bit inr;
        int a;
        acc = req_valid && m_ready[i];
        edges[i] = edges[i] + 1;
        m_ready[i] = clr(i) ? (edges[i] >= dep(i)) : (edges[i] >= 1);
        if (acc) begin
            a   = int'(req_addr);
            inr = a < dep(i);
            f_due[i][f_tail[i]] = edges[i] + lat(i) - 1;
            f_err[i][f_tail[i]] = !inr;
            if (req_write) begin
                f_dat[i][f_tail[i]] = 8'h00;
                f_kn[i][f_tail[i]]  = 1'b1;
                if (inr) begin
                    m_mem[i][a]   = req_wdata;
                    m_known[i][a] = 1'b1;
                end
            end else begin
                f_dat[i][f_tail[i]] = inr ? m_mem[i][a] : 8'h00;
                f_kn[i][f_tail[i]]  = inr ? m_known[i][a] : 1'b1;
            end
            f_tail[i] = (f_tail[i] + 1) % 64;
        end
        e_valid[i] = 1'b0;
        e_err[i]   = 1'b0;
        e_kn[i]    = 1'b1;
        e_dat[i]   = 8'h00;
        if (f_head[i] != f_tail[i] && f_due[i][f_head[i]] == edges[i]) begin
            e_valid[i] = 1'b1;
            e_err[i]   = f_err[i][f_head[i]];
            e_dat[i]   = f_dat[i][f_head[i]];
            e_kn[i]    = f_kn[i][f_head[i]];
            f_head[i]  = (f_head[i] + 1) % 64;
        end
    endfunction

    // Model advances on every rising edge, sampling the same inputs as the DUTs.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) model_reset(i);
            else        model_step(i);
        end
    end

    // ---------------- checking ----------------
    function automatic void chk_b(string nm, int i, logic act, logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d: got %b expected %b at %0t", nm, i, act, exp, $time);
        end
    endfunction

    function automatic void chk_d(string nm, int i, logic [7:0] act, logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d: got %h expected %h at %0t", nm, i, act, exp, $time);
        end
    endfunction

    // Every falling edge: all outputs of every configuration against the model.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                chk_b("rst_ready", i, rdy[i], 1'b0);
                chk_b("rst_init",  i, ini[i], 1'b0);
                chk_b("rst_valid", i, vld[i], 1'b0);
                chk_b("rst_err",   i, err[i], 1'b0);
                chk_d("rst_data",  i, dat[i], 8'h00);
            end else begin
                chk_b("ready", i, rdy[i], m_ready[i]);
                chk_b("init",  i, ini[i], m_ready[i]);
                chk_b("valid", i, vld[i], e_valid[i]);
                chk_b("err",   i, err[i], e_err[i]);
                if (e_kn[i]) chk_d("data", i, dat[i], e_dat[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit w, input int a, input int d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = 5'(a);
        req_wdata = 8'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 5'd0;
        req_wdata = 8'h00;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Init: a read held pending must be ignored until each config is ready.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'd3;
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk);
            #1;
            chk_b("lit_ready_init", 0, rdy[0], k >= 32);
            chk_b("lit_ready_init", 1, rdy[1], k >= 20);
            chk_b("lit_ready_init", 2, rdy[2], 1'b1);
            chk_b("lit_done_init",  0, ini[0], k >= 32);
            if (k == 19) req_valid = 1'b0;
        end

        // Cleared memory reads back zero everywhere.
        for (int a = 0; a < 32; a++) begin
            issue(1'b0, a, 0);
            chk_b("lit_rd0_valid", 0, vld[0], 1'b1);
            chk_d("lit_rd0_data",  0, dat[0], 8'h00);
        end

        // Back-to-back write then read of the same address.
        issue(1'b1, 5, 8'h41);
        chk_b("lit_wr_valid", 0, vld[0], 1'b1);
        chk_d("lit_wr_data",  0, dat[0], 8'h00);
        issue(1'b0, 5, 0);
        chk_b("lit_rd_valid", 0, vld[0], 1'b1);
        chk_d("lit_rd_data",  0, dat[0], 8'h41);
        chk_b("lit_rd_err",   0, err[0], 1'b0);

        // Streaming: fill, then 32 back-to-back reads; latency-3 config trails by 2.
        for (int a = 0; a < 32; a++) issue(1'b1, a, a + 8'h20);
        for (int a = 0; a < 32; a++) begin
            issue(1'b0, a, 0);
            if (a >= 2) begin
                chk_b("lit_stream_valid", 1, vld[1], 1'b1);
                chk_b("lit_stream_err",   1, err[1], (a - 2) >= 20);
                chk_d("lit_stream_data",  1, dat[1], ((a - 2) < 20) ? 8'(8'h20 + (a - 2)) : 8'h00);
            end
        end
        for (int j = 0; j < 2; j++) begin
            idle(1);
            chk_b("lit_stream_tail", 1, vld[1], 1'b1);
            chk_b("lit_stream_err",  1, err[1], 1'b1);
        end

        // Uncleared config: write then read addr 0, response 4 edges later.
        issue(1'b1, 0, 8'h5A);
        issue(1'b0, 0, 0);
        idle(3);
        chk_b("lit_nc_valid", 2, vld[2], 1'b1);
        chk_d("lit_nc_data",  2, dat[2], 8'h5A);
        chk_b("lit_nc_err",   2, err[2], 1'b0);

        // Out of range on the 20-word config; addr 19 holds its streamed value.
        issue(1'b1, 25, 8'hFF);
        issue(1'b0, 25, 0);
        issue(1'b0, 19, 0);
        chk_b("lit_oor_wr_err",  1, err[1], 1'b1);
        chk_d("lit_oor_wr_data", 1, dat[1], 8'h00);
        idle(1);
        chk_b("lit_oor_rd_err",  1, err[1], 1'b1);
        chk_d("lit_oor_rd_data", 1, dat[1], 8'h00);
        idle(1);
        chk_b("lit_in_rd_err",   1, err[1], 1'b0);
        chk_d("lit_in_rd_data",  1, dat[1], 8'h33);

        // Reset mid-stream: in-flight reads must never surface.
        issue(1'b0, 5, 0);
        issue(1'b0, 6, 0);
        issue(1'b0, 7, 0);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) chk_b("lit_rst_valid", i, vld[i], 1'b0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) chk_b("lit_reinit_valid", i, vld[i], 1'b0);
        end
        issue(1'b0, 5, 0);
        chk_b("lit_reclr_valid", 0, vld[0], 1'b1);
        chk_d("lit_reclr_data",  0, dat[0], 8'h00);
        issue(1'b0, 6, 0);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
